bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter using reverse double dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is ≥ 8. It is the inverse of the team's binary-to-BCD converter. It sits between decimal-entry logic (keypads, BCD counters) and binary arithmetic datapaths. Conversion is started by a one-cycle `start` and completes with a one-cycle `done` pulse.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adjust.sv | 18 +
 rtl/bcd_to_binary.sv | 146 ++++++++++++++
 tb/tb_bcd_to_binary.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion blocks.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd2bin_state_t;

    localparam logic [3:0] BCD_ADJ        = 4'd3;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;

    // True when the nibble is a legal decimal digit.
    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for reverse double dabble: a digit that reached 8 or more after
// the right shift carried a half-ten (5 = 8 - 3) from the digit above, so subtract 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Subtract the correction when the threshold is reached; 4-bit result, no borrow out.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_ADJ_THRESH) begin
            digit_out = digit_in - BCD_ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double dabble), one shift per cycle.
// Optional build macro BCD_TO_BIN_CHECK_EN: rejects inputs containing a digit > 9
// with a one-cycle error completion instead of converting them.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  error
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    bcd2bin_state_t      state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    binary_out_q, binary_out_d;
    logic                done_q, done_d;

    logic [WORK_W-1:0]   work_shifted;
    logic [WORK_W-1:0]   work_adj;

    assign work_shifted = work_q >> 1;

    // Binary field passes straight through; each BCD digit gets its own correction.
    assign work_adj[BIN_W-1:0] = work_shifted[BIN_W-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (work_shifted[BIN_W + 4*i +: 4]),
            .digit_out (work_adj[BIN_W + 4*i +: 4])
        );
    end

`ifdef BCD_TO_BIN_CHECK_EN
    logic error_q, error_d;
    logic bcd_has_invalid;

    // Flag any nibble of the incoming value that is not a decimal digit.
    always_comb begin
        bcd_has_invalid = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!bcd_digit_valid(bcd_in[4*i +: 4])) begin
                bcd_has_invalid = 1'b1;
            end
        end
    end
`endif

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        binary_out_d = binary_out_q;
        done_d       = 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
        error_d      = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef BCD_TO_BIN_CHECK_EN
                    if (bcd_has_invalid) begin
                        // Bin field of a cleared work register gives the zero result.
                        error_d = 1'b1;
                        work_d  = '0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b0;
                        work_d  = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
`else
                    work_d  = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                work_d = work_adj;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                binary_out_d = work_q[BIN_W-1:0];
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            work_q       <= '0;
            cnt_q        <= '0;
            binary_out_q <= '0;
            done_q       <= 1'b0;
`ifdef BCD_TO_BIN_CHECK_EN
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            binary_out_q <= binary_out_d;
            done_q       <= done_d;
`ifdef BCD_TO_BIN_CHECK_EN
            error_q      <= error_d;
`endif
        end
    end

    // The done pulse lands after leaving DONE, so busy stays up through it.
    assign busy       = (state_q != IDLE) || done_q;
    assign done       = done_q;
    assign binary_out = binary_out_q;

`ifdef BCD_TO_BIN_CHECK_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  binary_out;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bcd_to_binary #(
        .DIGITS (3),
        .BIN_W  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .done       (done),
        .binary_out (binary_out),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Start a conversion (called 1 time unit after a rising edge) and check its result.
    task automatic convert(input logic [11:0] bcd, input logic [9:0] exp, input string name,
                           output int acc_cyc);
        int n;
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        start  = 1'b0;
        bcd_in = 12'h000;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b want 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL %s latency got %0d want 11", name, n);
        end
        checks++;
        if (binary_out !== exp) begin
            errors++;
            $display("FAIL %s binary_out got %0d want %0d", name, binary_out, exp);
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL %s error got %b want 0", name, error);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, busy, error} !== 3'b000 || binary_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_state got done=%b busy=%b error=%b out=%0d want all 0",
                     done, busy, error, binary_out);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_values();
        int a;
        convert(12'h999, 10'd999, "bcd_999", a);
        convert(12'h000, 10'd0,   "bcd_000", a);
        convert(12'h001, 10'd1,   "bcd_001", a);
        convert(12'h255, 10'd255, "bcd_255", a);
        convert(12'h510, 10'd510, "bcd_510", a);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_busy_protect();
        int n_done = 0;
        int first_at = -1;
        logic [9:0] first_val = '0;
        start  = 1'b1;
        bcd_in = 12'h123;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'h000;
        for (int c = 1; c <= 30; c++) begin
            if (c == 4) begin
                start  = 1'b1;
                bcd_in = 12'h456;
            end else begin
                start  = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                if (first_at < 0) begin
                    first_at  = c;
                    first_val = binary_out;
                end
            end
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL busy_protect done_count got %0d want 1", n_done);
        end
        checks++;
        if (first_val !== 10'd123) begin
            errors++;
            $display("FAIL busy_protect binary_out got %0d want 123", first_val);
        end
        checks++;
        if (first_at !== 11) begin
            errors++;
            $display("FAIL busy_protect latency got %0d want 11", first_at);
        end
    endtask

    task automatic test_mid_reset();
        int n_done = 0;
        int a;
        start  = 1'b1;
        bcd_in = 12'h999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy, error} !== 3'b000 || binary_out !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset outputs got done=%b busy=%b error=%b out=%0d want all 0",
                     done, busy, error, binary_out);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL mid_reset stray_done got %0d want 0", n_done);
        end
        convert(12'h042, 10'd42, "after_reset_042", a);
    endtask

`ifdef BCD_TO_BIN_CHECK_EN
    task automatic test_invalid_digit();
        int n = 0;
        int a;
        start  = 1'b1;
        bcd_in = 12'h1A5;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL invalid latency got %0d want 1", n);
        end
        checks++;
        if (error !== 1'b1 || binary_out !== 10'd0) begin
            errors++;
            $display("FAIL invalid result got error=%b out=%0d want 1 0", error, binary_out);
        end
        convert(12'h100, 10'd100, "valid_after_invalid", a);
    endtask
`endif

    task automatic test_back_to_back();
        int prev_acc;
        int acc;
        int d2, d1, d0;
        logic [9:0] exp;
        prev_acc = -1;
        for (int k = 0; k < 8; k++) begin
            d2  = $urandom_range(9, 0);
            d1  = $urandom_range(9, 0);
            d0  = $urandom_range(9, 0);
            exp = 10'(d2 * 100 + d1 * 10 + d0);
            convert({4'(d2), 4'(d1), 4'(d0)}, exp, "back_to_back", acc);
            if (prev_acc >= 0) begin
                checks++;
                if (acc - prev_acc !== 12) begin
                    errors++;
                    $display("FAIL back_to_back period got %0d want 12", acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_busy_protect();
        test_mid_reset();
`ifdef BCD_TO_BIN_CHECK_EN
        test_invalid_digit();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
